// File: rtl/i2c_ram_ctl.sv
// i2c_ram_ctl: memory-side engine behind i2c_slave.
//  - 2^LD_NBYTES x 8 register RAM.
//  - I2C register pointer of 1 or 2 bytes (ADDR_BYTES), sent MSB first.
//  - Pointer auto-increments modulo the RAM depth.
//  - A local host port gives the fabric read/write access to the same RAM.
// Optional feature macro: I2C_RAM_WP_EN
//  - When defined, I2C writes to addresses >= WP_BASE are discarded.
//  - The pointer still advances on a discarded write.
module i2c_ram_ctl #(
  parameter int LD_NBYTES  = 3,
  parameter int ADDR_BYTES = 1,
  parameter int WP_BASE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 as_in,
  input  logic                 ws_in,
  input  logic                 rs_in,
  input  logic [7:0]           wdat_in,
  output logic [7:0]           rdat_out,
  input  logic [LD_NBYTES-1:0] h_addr,
  input  logic                 h_we,
  input  logic [7:0]           h_wdata,
  input  logic                 h_re,
  output logic [7:0]           h_rdata,
  output logic                 h_rvalid,
  output logic                 h_wcoll,
  output logic                 i2c_wr,
  output logic [LD_NBYTES-1:0] i2c_wr_addr
);

  localparam int AW    = LD_NBYTES;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_PTR_LO = 2'd1,
    ST_PTR_HI = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [15:0]   ptr16;
  logic          i2c_we;
  logic          wp_ok;
  logic          host_coll;
  logic [7:0]    mem [0:DEPTH-1];

  // Pointer viewed as a 16-bit {hi,lo} pair.
  // Pointer bytes can then be merged and truncated back to AW bits uniformly.
  assign ptr16 = 16'(ptr);

`ifdef I2C_RAM_WP_EN
  assign wp_ok = (32'(ptr) < 32'(WP_BASE));
`else
  assign wp_ok = 1'b1;
`endif

  // A host write loses to an I2C data write that targets the same address.
  assign host_coll = h_we && i2c_we && (h_addr == ptr);

  // Next-state, next-pointer and I2C write enable.
  // as_in has priority over the byte strobes.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    i2c_we    = 1'b0;
    if (as_in) begin
      state_nxt = (ADDR_BYTES == 2) ? ST_PTR_HI : ST_PTR_LO;
    end else if (ws_in) begin
      case (state)
        ST_PTR_HI: begin
          ptr_nxt   = AW'({wdat_in, ptr16[7:0]});
          state_nxt = ST_PTR_LO;
        end
        ST_PTR_LO: begin
          ptr_nxt   = AW'({ptr16[15:8], wdat_in});
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          i2c_we  = wp_ok;
          ptr_nxt = ptr + AW'(1);
        end
        default: state_nxt = ST_DATA;
      endcase
    end else if (rs_in) begin
      // A current-address read keeps whatever pointer bytes were already loaded.
      ptr_nxt   = ptr + AW'(1);
      state_nxt = ST_DATA;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_DATA;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // RAM write ports.
  // The I2C port always commits; the host port is dropped on a same-address collision.
  always_ff @(posedge clk) begin
    if (i2c_we)
      mem[ptr] <= wdat_in;
    if (h_we && !host_coll)
      mem[h_addr] <= h_wdata;
  end

  // Registered read data and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat_out    <= '0;
      h_rdata     <= '0;
      h_rvalid    <= 1'b0;
      h_wcoll     <= 1'b0;
      i2c_wr      <= 1'b0;
      i2c_wr_addr <= '0;
    end else begin
      rdat_out <= mem[ptr];
      h_rvalid <= h_re;
      if (h_re)
        h_rdata <= mem[h_addr];
      h_wcoll <= host_coll;
      i2c_wr  <= i2c_we;
      if (i2c_we)
        i2c_wr_addr <= ptr;
    end
  end

endmodule
